mul16_seq: RTL and testbench



---
 rtl/mul16_seq.sv | 133 +++++++++++++
 tb/tb_mul16_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mul16_seq.sv
// Iterative 16x16 unsigned shift-and-add multiplier for the HACK datapath.
// One Add16 ripple adder forms each partial sum; 16 RUN cycles give the 32-bit product.

module Add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] Sum,
  output logic        Carry
);

  logic c;

  // Explicit bit-serial ripple chain, the multiplier's critical path.
  always_comb begin
    c   = cin;
    Sum = '0;
    for (int i = 0; i < 16; i++) begin
      Sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    Carry = c;
  end

endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        overflow
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [W-1:0]  mcand, mcand_nxt;
  logic [W-1:0]  acc, acc_nxt;
  logic [W-1:0]  mq, mq_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2*W-1:0] product_nxt;
  logic          overflow_nxt;
  logic          busy_nxt, done_nxt;
  logic [W-1:0]  sum;
  logic          carry;

  Add16 u_add (
    .a     (acc),
    .b     (mcand),
    .cin   (1'b0),
    .Sum   (sum),
    .Carry (carry)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mcand    <= '0;
      acc      <= '0;
      mq       <= '0;
      cnt      <= '0;
      product  <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      mcand    <= mcand_nxt;
      acc      <= acc_nxt;
      mq       <= mq_nxt;
      cnt      <= cnt_nxt;
      product  <= product_nxt;
      overflow <= overflow_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state and datapath update; the adder carry shifts into acc[15] so nothing is lost
  always_comb begin
    state_nxt    = state;
    mcand_nxt    = mcand;
    acc_nxt      = acc;
    mq_nxt       = mq;
    cnt_nxt      = cnt;
    product_nxt  = product;
    overflow_nxt = overflow;

    case (state)
      S_IDLE: begin
        if (start) begin
          mcand_nxt = x;
          mq_nxt    = y;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (mq[0]) begin
          acc_nxt = {carry, sum[W-1:1]};
          mq_nxt  = {sum[0], mq[W-1:1]};
        end else begin
          acc_nxt = {1'b0, acc[W-1:1]};
          mq_nxt  = {acc[0], mq[W-1:1]};
        end
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          product_nxt  = {acc_nxt, mq_nxt};
          overflow_nxt = |acc_nxt;
          state_nxt    = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: cycle-level reference model plus directed
// literal checks, ending with 1000 back-to-back random multiplies.

module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x, y;
  logic        busy, done, overflow;
  logic [31:0] product;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  // Reference model: phase k means k cycles since the accepting edge, 0 = idle
  int          phase = 0;
  logic [31:0] pend = '0;
  logic [31:0] exp_prod = '0;
  logic        exp_ovf = 1'b0;

  mul16_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase    = 0;
      exp_prod = '0;
      exp_ovf  = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase = 1;
        pend  = 32'(x) * 32'(y);
      end
    end else if (phase == 17) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == 17) begin
        exp_prod = pend;
        exp_ovf  = |pend[31:16];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy",     32'(busy),     32'(phase != 0));
      chk("done",     32'(done),     32'(phase == 17));
      chk("product",  product,       exp_prod);
      chk("overflow", 32'(overflow), 32'(exp_ovf));
    end
  end

  // Accept one operation from idle, wait for done, check latency and literal result
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] want, input logic want_ovf);
    int k;
    @(negedge clk);
    start = 1'b1; x = a; y = b;
    @(negedge clk);
    start = 1'b0; x = 16'hDEAD; y = 16'hBEEF;
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'd17);
    chk("lit_product", product, want);
    chk("lit_overflow", 32'(overflow), 32'(want_ovf));
  endtask

  initial begin
    int ndone;
    int last_done;
    int k;
    logic [31:0] want;

    rst_n = 1'b0; start = 1'b1; x = 16'd3; y = 16'd5;
    @(negedge clk);
    check_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("rst_product", product, 32'h0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", 32'(busy), 32'd0);

    run_op(16'd3, 16'd5, 32'h0000000F, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    run_op(16'h1234, 16'h0000, 32'h00000000, 1'b0);

    // start pulses while busy must be ignored
    @(negedge clk);
    start = 1'b1; x = 16'd7; y = 16'd9;
    ndone = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("busy_ign_done_cycle", 32'(i), 32'd17);
      end
      if (i == 19) chk("busy_ign_idle", 32'(busy), 32'd0);
      start = (i == 5 || i == 17);
      x = 16'd2; y = 16'd2;
    end
    start = 1'b0;
    chk("busy_ign_ndone", 32'(ndone), 32'd1);
    chk("busy_ign_product", product, 32'h0000003F);

    // reset in the middle of a run aborts it
    @(negedge clk);
    start = 1'b1; x = 16'h00FF; y = 16'h0100;
    ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
      if (i == 9) begin
        chk("midrst_idle", 32'(busy), 32'd0);
        chk("midrst_product", product, 32'h0);
      end
      rst_n = (i != 8);
    end
    chk("midrst_ndone", 32'(ndone), 32'd0);
    run_op(16'd4, 16'd4, 32'h00000010, 1'b0);

    // back-to-back random multiplies with start held high
    @(negedge clk);
    start = 1'b1;
    x = 16'($urandom); y = 16'($urandom);
    last_done = -1;
    for (int i = 0; i < 1000; i++) begin
      want = 32'(x) * 32'(y);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done && k < 40);
      chk("b2b_done_seen", 32'(done), 32'd1);
      chk("b2b_product", product, want);
      if (last_done >= 0) chk("b2b_spacing", 32'(cyc - last_done), 32'd18);
      last_done = cyc;
      x = 16'($urandom); y = 16'($urandom);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
